// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback ports onto one register-file write port, with a bulk init fill
module regfile_wb_arbiter #(
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        init_start,
  input  logic [31:0] init_data,
  output logic        reg_write,
  output logic [4:0]  w_reg0,
  output logic [31:0] w_data,
  output logic        busy,
  output logic        init_done
);
  typedef enum logic {ARB, INIT} state_t;
  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        ptr;
  logic        arb, g0, g1, init_wr, hs_wr;
  logic [4:0]  hs_addr;
  logic [31:0] hs_data;
  assign arb        = reset_n && state == ARB && !init_start;
  assign g0         = arb && req0_valid && (PRIO_MODE || !req1_valid || !ptr);
  assign g1         = arb && req1_valid && !g0;
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign hs_addr    = g0 ? req0_addr : req1_addr;
  assign hs_data    = g0 ? req0_data : req1_data;
  assign init_wr    = state == INIT;
  assign hs_wr      = (g0 || g1) && hs_addr != 5'd0;
  // next state and fill counter: the counter runs 1..31 and then drops back to ARB
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == ARB && init_start) begin
      state_nx = INIT;
      cnt_nx   = 5'd1;
    end else if (state == INIT) begin
      state_nx = cnt == 5'd31 ? ARB : INIT;
      cnt_nx   = cnt == 5'd31 ? 5'd0 : cnt + 5'd1;
    end
  end
  // registered write port, round-robin pointer (1 = favour req1) and init status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB;
      cnt       <= 5'd0;
      ptr       <= 1'b0;
      reg_write <= 1'b0;
      w_reg0    <= 5'd0;
      w_data    <= 32'd0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      if (g0 || g1) ptr <= g0;
      reg_write <= init_wr || hs_wr;
      if (init_wr) begin
        w_reg0 <= cnt;
        w_data <= init_data;
      end else if (hs_wr) begin
        w_reg0 <= hs_addr;
        w_data <= hs_data;
      end
      busy      <= init_wr || init_start;
      init_done <= init_wr && cnt == 5'd31;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = round-robin between requesters; 1 = fixed priority, req0 always wins.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_addr  input  5  requester 0 destination register.
REQ-006 req0_data  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 write accepted this cycle when high with req0_valid.
REQ-008 req1_valid / req1_addr / req1_data / req1_ready  in/in/in/out  1/5/32/1  requester 1 (load writeback), same meaning.
REQ-009 init_start  input  1  one-cycle request to fill registers 1..31 with init_data.
REQ-010 init_data  input  32  fill value, sampled every init write cycle.
REQ-011 reg_write  output  1  register-file write enable.
REQ-012 w_reg0  output  5  register-file write select.
REQ-013 w_data  output  32  register-file write data.
REQ-014 busy  output  1  init sequence in progress.
REQ-015 init_done  output  1  one-cycle pulse on the last init write.

Function
REQ-016 The block SHALL have two states, ARB and INIT; the reset state is ARB.
REQ-017 reg_write, w_reg0, w_data, busy and init_done SHALL be registered outputs; the readies SHALL be combinational.
REQ-018 In ARB with init_start low, the block SHALL raise the ready of exactly one valid requester, or of none if neither is valid.
REQ-019 When only one requester is valid, that requester SHALL be granted.
REQ-020 When both are valid and PRIO_MODE=0, the requester not granted last SHALL win; after reset the pointer SHALL favour req0.
REQ-021 When PRIO_MODE=1, req0 SHALL win every conflict.
REQ-022 The round-robin pointer SHALL update only on a completed handshake (valid&&ready).
REQ-023 A handshake in cycle T SHALL produce reg_write=1, w_reg0=addr, w_data=data in cycle T+1, for exactly one cycle.
REQ-024 Sustained throughput SHALL be one write per cycle.
REQ-025 A handshake with addr=0 SHALL complete normally and update the pointer, but SHALL leave reg_write=0 in T+1 ($zero is never written).
REQ-026 Without a handshake, reg_write SHALL be 0 in the next cycle; w_reg0 and w_data SHALL hold their previous values.
REQ-027 init_start high in ARB SHALL force both readies low in that cycle (init wins over simultaneous requests) and enter INIT at the next edge.
REQ-028 INIT SHALL step a 5-bit counter 1..31, one per cycle.
REQ-029 For init_start sampled in cycle T, writes to registers 1..31 with init_data SHALL appear in cycles T+2..T+32.
REQ-030 init_done SHALL be high only in cycle T+32.
REQ-031 busy SHALL be high in cycles T+1..T+32.
REQ-032 The state SHALL return to ARB so readies may assert from T+32.
REQ-033 In INIT both readies SHALL be 0, and init_start SHALL be ignored.
REQ-034 The counter SHALL not wrap; register 0 SHALL never be written by init.

Reset
REQ-035 With reset_n low at a rising edge, the block SHALL load: state=ARB, counter=0, pointer=req0, reg_write=0, w_reg0=0, w_data=0, busy=0, init_done=0.
REQ-036 Readies SHALL be 0 while reset_n is low.
REQ-037 Reset asserted mid-INIT SHALL abort the sequence; no further init writes and no init_done pulse SHALL occur.

Verification
REQ-038 Single write: req0 valid, addr=5, data=0xDEADBEEF in cycle T -> req0_ready=1 in T; in T+1 reg_write=1, w_reg0=5, w_data=0xDEADBEEF; in T+2 reg_write=0.
REQ-039 Conflict, PRIO_MODE=0: both valid for 4 cycles (req0 addr=1, req1 addr=2) -> grants req0,req1,req0,req1; w_reg0 sequence 1,2,1,2. With PRIO_MODE=1 -> all four grants to req0.
REQ-040 $zero drop: req1 valid, addr=0, data=0x1234 -> req1_ready=1; reg_write stays 0 in the next cycle.
REQ-041 Init: init_data=0xA5A5A5A5, init_start pulse at T with req0 valid -> req0_ready=0 in T..T+31; w_reg0 counts 1..31 in T+2..T+32 with reg_write=1; init_done=1 only at T+32; req0 granted at T+32 and written at T+33.
REQ-042 Reset mid-init: reset_n low at T+10 of an init sequence -> all outputs at reset values from T+11; reg_write stays 0 and init_done never pulses.
